vector_register_file: RTL
=========================

# vector_register_file

Parametrised vector register file, successor to the scalar register file in the ASIP datapath. Holds `registerQuantity` vectors of `laneCount` lanes by `laneWidth` bits. It provides two combinational full-vector read ports and one lane-masked ALU write port. A beat-serial load port assembles a vector from memory over several valid/ready beats and commits it atomically, with a per-register busy flag for hazard detection.

## Interface
Parameters:
- `laneWidth`, 8, bits per lane
- `laneCount`, 4, lanes per vector register
- `registerQuantity`, 8, number of vector registers
- `selectionBits`, 3, register select width (2^selectionBits ≥ registerQuantity)
- `beatLanes`, 1, lanes delivered per load beat; laneCount % beatLanes == 0

Ports (VW = laneCount*laneWidth, BW = beatLanes*laneWidth):
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; clears all state when 0
- `rSel1`, `rSel2` in selectionBits: read selects
- `reg1Out`, `reg2Out` out VW: selected vectors; lane i at bits [i*laneWidth +: laneWidth]
- `reg1Busy`, `reg2Busy` out 1: load pending on the selected register
- `regWrEn` in 1: ALU write enable
- `regToWrite` in selectionBits: ALU write target
- `wrMask` in laneCount: per-lane write enable
- `dataIn` in VW: ALU write data
- `ldStart` in 1: request a load into `ldSel`
- `ldSel` in selectionBits: load target
- `ldValid` in 1, `ldReady` out 1, `ldData` in BW: beat handshake
- `ldBusy` out 1: load FSM not IDLE
- `ldDone` out 1: one-cycle pulse after commit

## Operation
- Reads are combinational from register storage with no write bypass. A write becomes visible on read ports the cycle after its edge.
- ALU write: on an edge with `regWrEn`=1, lanes with `wrMask[i]`=1 of `regs[regToWrite]` take `dataIn` lanes. Other lanes hold.
- `regToWrite` or `ldSel` ≥ registerQuantity: write is ignored. Reads of an out-of-range register return 0.
- Load FSM, with states IDLE, FILL and COMMIT:
  - IDLE: `ldStart`=1 (and ldSel in range) captures ldSel, sets `busy[ldSel]`, clears the beat counter, and moves to FILL. `ldStart` in any other state is ignored.
  - FILL: `ldReady`=1. Each edge with `ldValid&&ldReady` writes `ldData` into staging lanes [k*beatLanes +: beatLanes] for beat k, then k++. After beat laneCount/beatLanes−1 is accepted, the FSM goes to COMMIT.
  - COMMIT: `ldReady`=0. Conflict means `regWrEn`=1 and `regToWrite`==target.
    - No conflict: the full staging vector is written to the target (all lanes, no mask), `busy` is cleared, `ldDone` is set for the next cycle, and the FSM goes to IDLE.
    - Conflict: the ALU write wins that edge and the FSM stays in COMMIT.
- An ALU write to a busy register is permitted. The later commit overwrites it, and the hazard is the issuer's responsibility via `regNBusy`.
- `regNBusy` = `busy[rSelN]`.

## Timing
- Reset (`reset`=0, async) sets every register to 0, all busy bits to 0, the FSM to IDLE, and the beat counter and staging to 0. It forces `ldReady`=0, `ldBusy`=0 and `ldDone`=0, and `reg1Out`/`reg2Out` read 0. Reset mid-load abandons the load with no partial commit.
- `ldStart` sampled at edge t: FILL from t+1. With a beat every cycle, the last beat is accepted at edge t+N (N=laneCount/beatLanes). COMMIT runs during cycle t+N+1, the register is written at edge t+N+1, and `ldDone`=1 with new data readable in cycle t+N+2. `ldBusy` falls then as well.
- `ldValid`=0 in FILL stalls indefinitely. The counter does not wrap mid-load and resets on the next ldStart.
- `ldDone` is high for exactly one cycle. A new `ldStart` is accepted in that same cycle.

## Structure
- Package `vrf_pkg` holds the load-state enum (IDLE, FILL, COMMIT) and helper localparams for vector width and beat count.
- The natural sub-module is `vector_load_sequencer`: the FSM, beat counter, staging buffer, and commit request/grant. The top owns storage, read muxing, busy bits and the write-port arbitration.

## Test plan
All scenarios use default parameters unless noted.
- Reset, then read all registers → all 0, `ldReady`=0, busy=0. Assert reset mid-FILL → FSM IDLE, target register still 0.
- Masked write: write reg 2 = 0xFEDCBA98 with mask 1111, then reg 2 with mask 0101 and data 0x11223344 → next-cycle read gives 0xFE22BA44.
- Load into reg 5 with beats 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles → `reg1Busy`=1 (rSel1=5) throughout. `ldDone` pulses and reg 5 = 0xD4C3B2A1 exactly 6 cycles after ldStart (N=4).
- Load with `ldValid` dropped for 3 cycles mid-fill → same final value, done delayed by 3 cycles. `ldStart` during the load is ignored.
- Commit conflict: in the COMMIT cycle drive regWrEn to reg 5 with 0x0 → ALU write lands first and commit lands one cycle later. Final reg 5 = load data, `ldDone` one cycle later.
- beatLanes=2: two beats 0xB2A1, 0xD4C3 → vector 0xD4C3B2A1, done 4 cycles after ldStart.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file.
// Contents:
//   ld_state_t      - load sequencer states (IDLE, FILL, COMMIT)
//   DEF_*           - default geometry used as parameter defaults
//   vec_width()     - bits per vector register
//   beat_count()    - beats needed to assemble one vector
//   count_width()   - beat counter width (never zero bits)
package vrf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } ld_state_t;

    localparam int DEF_LANE_WIDTH        = 8;
    localparam int DEF_LANE_COUNT        = 4;
    localparam int DEF_REGISTER_QUANTITY = 8;
    localparam int DEF_SELECTION_BITS    = 3;
    localparam int DEF_BEAT_LANES        = 1;

    function automatic int vec_width(input int lane_count, input int lane_width);
        return lane_count * lane_width;
    endfunction

    function automatic int beat_count(input int lane_count, input int beat_lanes);
        return lane_count / beat_lanes;
    endfunction

    // A single-beat load still needs a one-bit counter to keep the logic legal.
    function automatic int count_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int DEF_VEC_WIDTH  = vec_width(DEF_LANE_COUNT, DEF_LANE_WIDTH);
    localparam int DEF_BEAT_COUNT = beat_count(DEF_LANE_COUNT, DEF_BEAT_LANES);

endpackage

// File: rtl/vector_load_sequencer.sv
// Beat-serial vector load sequencer.
// Collects laneCount/beatLanes beats from a valid/ready stream into a
// staging buffer, then requests a single full-vector commit to the target
// register and retries until the register file grants it.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   start/start_sel - load request and target (target already range-checked)
//   start_accept    - pulse: request taken this cycle (sets target busy bit)
//   beat_valid/beat_ready/beat_data - beat handshake
//   busy            - sequencer not idle
//   done            - one-cycle pulse the cycle after the commit edge
//   commit_req/commit_sel/commit_data - commit request towards storage
//   commit_grant    - storage accepts the commit on this edge
module vector_load_sequencer
    import vrf_pkg::*;
#(
    parameter int laneWidth     = DEF_LANE_WIDTH,
    parameter int laneCount     = DEF_LANE_COUNT,
    parameter int selectionBits = DEF_SELECTION_BITS,
    parameter int beatLanes     = DEF_BEAT_LANES
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [selectionBits-1:0]           start_sel,
    output logic                               start_accept,
    input  logic                               beat_valid,
    output logic                               beat_ready,
    input  logic [beatLanes*laneWidth-1:0]     beat_data,
    output logic                               busy,
    output logic                               done,
    output logic                               commit_req,
    output logic [selectionBits-1:0]           commit_sel,
    output logic [laneCount*laneWidth-1:0]     commit_data,
    input  logic                               commit_grant
);

    localparam int BW    = beatLanes * laneWidth;
    localparam int BEATS = beat_count(laneCount, beatLanes);
    localparam int CNT_W = count_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    ld_state_t                state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg;
    logic [selectionBits-1:0] target_reg;
    logic [BW-1:0]            stage_reg [BEATS];
    logic                     done_reg;
    logic                     beat_accept;
    logic                     last_beat;

    assign last_beat = (cnt_reg == LAST_BEAT);

    always_comb begin
        state_next   = state_reg;
        start_accept = 1'b0;
        beat_ready   = 1'b0;
        beat_accept  = 1'b0;
        commit_req   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = FILL;
                end
            end
            FILL: begin
                beat_ready = 1'b1;
                if (beat_valid) begin
                    beat_accept = 1'b1;
                    if (last_beat) begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                // Held here while an ALU write to the same register wins the port.
                commit_req = 1'b1;
                if (commit_grant) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            target_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= commit_req && commit_grant;
            if (start_accept) begin
                cnt_reg    <= '0;
                target_reg <= start_sel;
            end else if (beat_accept && !last_beat) begin
                // Saturates on the last beat; only a new start rewinds it.
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int bi = 0; bi < BEATS; bi++) begin
                stage_reg[bi] <= '0;
            end
        end else if (beat_accept) begin
            for (int bi = 0; bi < BEATS; bi++) begin
                if (cnt_reg == CNT_W'(bi)) begin
                    stage_reg[bi] <= beat_data;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_pack
            assign commit_data[gi*BW +: BW] = stage_reg[gi];
        end
    endgenerate

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign commit_sel = target_reg;

endmodule

// File: rtl/vector_register_file.sv
// Vector register file: registerQuantity vectors of laneCount x laneWidth.
// Two combinational full-vector read ports (no write bypass), one
// lane-masked ALU write port, and a beat-serial load port whose commit
// yields to a same-cycle ALU write to the same register.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   rSel1/rSel2                - read selects
//   reg1Out/reg2Out            - read data (0 for out-of-range selects)
//   reg1Busy/reg2Busy          - load pending on the selected register
//   regWrEn/regToWrite/wrMask/dataIn - ALU write port
//   ldStart/ldSel              - load request and target
//   ldValid/ldReady/ldData     - load beat handshake
//   ldBusy                     - load in progress
//   ldDone                     - one-cycle pulse after the load commit
module vector_register_file
    import vrf_pkg::*;
#(
    parameter int laneWidth        = DEF_LANE_WIDTH,
    parameter int laneCount        = DEF_LANE_COUNT,
    parameter int registerQuantity = DEF_REGISTER_QUANTITY,
    parameter int selectionBits    = DEF_SELECTION_BITS,
    parameter int beatLanes        = DEF_BEAT_LANES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [selectionBits-1:0]       rSel1,
    input  logic [selectionBits-1:0]       rSel2,
    output logic [laneCount*laneWidth-1:0] reg1Out,
    output logic [laneCount*laneWidth-1:0] reg2Out,
    output logic                           reg1Busy,
    output logic                           reg2Busy,
    input  logic                           regWrEn,
    input  logic [selectionBits-1:0]       regToWrite,
    input  logic [laneCount-1:0]           wrMask,
    input  logic [laneCount*laneWidth-1:0] dataIn,
    input  logic                           ldStart,
    input  logic [selectionBits-1:0]       ldSel,
    input  logic                           ldValid,
    output logic                           ldReady,
    input  logic [beatLanes*laneWidth-1:0] ldData,
    output logic                           ldBusy,
    output logic                           ldDone
);

    localparam int VW   = vec_width(laneCount, laneWidth);
    // Decode space covers every select code so out-of-range codes map to
    // constant-zero entries instead of needing explicit range compares.
    localparam int NSEL = 2 ** selectionBits;

    logic [NSEL-1:0]          reg_exists;
    logic [VW-1:0]            read_vec [NSEL];
    logic [NSEL-1:0]          busy_vec;
    logic                     start_req;
    logic                     start_accept;
    logic                     commit_req;
    logic                     commit_grant;
    logic                     write_conflict;
    logic [selectionBits-1:0] commit_sel;
    logic [VW-1:0]            commit_data;

    assign start_req      = ldStart && reg_exists[ldSel];
    // The ALU write owns the port on a collision; the commit retries next cycle.
    assign write_conflict = regWrEn && (regToWrite == commit_sel);
    assign commit_grant   = commit_req && !write_conflict;

    vector_load_sequencer #(
        .laneWidth    (laneWidth),
        .laneCount    (laneCount),
        .selectionBits(selectionBits),
        .beatLanes    (beatLanes)
    ) u_seq (
        .clk         (clk),
        .reset       (reset),
        .start       (start_req),
        .start_sel   (ldSel),
        .start_accept(start_accept),
        .beat_valid  (ldValid),
        .beat_ready  (ldReady),
        .beat_data   (ldData),
        .busy        (ldBusy),
        .done        (ldDone),
        .commit_req  (commit_req),
        .commit_sel  (commit_sel),
        .commit_data (commit_data),
        .commit_grant(commit_grant)
    );

    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_reg
            if (gi < registerQuantity) begin : g_live
                localparam logic [selectionBits-1:0] REG_IDX = selectionBits'(gi);

                logic [VW-1:0] vec_reg;
                logic          busy_reg;
                logic          alu_hit;
                logic          commit_hit;
                logic          load_hit;

                assign alu_hit    = regWrEn && (regToWrite == REG_IDX);
                assign commit_hit = commit_grant && (commit_sel == REG_IDX);
                assign load_hit   = start_accept && (ldSel == REG_IDX);

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        vec_reg <= '0;
                    end else begin
                        for (int li = 0; li < laneCount; li++) begin
                            if (alu_hit && wrMask[li]) begin
                                vec_reg[li*laneWidth +: laneWidth] <= dataIn[li*laneWidth +: laneWidth];
                            end
                        end
                        // Never coincides with alu_hit: the grant is withheld then.
                        if (commit_hit) begin
                            vec_reg <= commit_data;
                        end
                    end
                end

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        busy_reg <= 1'b0;
                    end else if (load_hit) begin
                        busy_reg <= 1'b1;
                    end else if (commit_hit) begin
                        busy_reg <= 1'b0;
                    end
                end

                assign reg_exists[gi] = 1'b1;
                assign read_vec[gi]   = vec_reg;
                assign busy_vec[gi]   = busy_reg;
            end else begin : g_absent
                assign reg_exists[gi] = 1'b0;
                assign read_vec[gi]   = '0;
                assign busy_vec[gi]   = 1'b0;
            end
        end
    endgenerate

    assign reg1Out  = read_vec[rSel1];
    assign reg2Out  = read_vec[rSel2];
    assign reg1Busy = busy_vec[rSel1];
    assign reg2Busy = busy_vec[rSel2];

endmodule
